// File: rtl/rvx_fetch_pkg.sv
// Shared constants and queue entry layout for the RVX instruction-fetch front end.
package rvx_fetch_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned PC_STEP  = 4;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [INST_W-1:0]   inst;
  } fetch_entry_t;

endpackage

// File: rtl/rvx_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; head data is read from storage.
module rvx_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // Flush takes priority over any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rvx_fetch_queue.sv
// RVX fetch front end: credit-limited IM requests, PC-tagged instruction queue, jump flush.
// Optional same-cycle response bypass to ID when built with RVX_FETCH_BYPASS_EN.
module rvx_fetch_queue
  import rvx_fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter int unsigned     MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imReqValidOut,
  input  logic                   imReqReadyIn,
  output logic [XLEN-1:0]        imAddrOut,
  input  logic                   imRspValidIn,
  input  logic [INST_W-1:0]      imRspDataIn,
  input  logic                   jumpEnIn,
  input  logic [XLEN-1:0]        jumpAddrIn,
  input  logic                   idReadyIn,
  output logic                   ifValidOut,
  output logic [INST_W-1:0]      ifInstOut,
  output logic [XLEN-1:0]        ifPcOut,
  output logic [XLEN-1:0]        ifPcPlusOut,
  output logic [$clog2(DEPTH):0] occupancyOut
);

  localparam int unsigned OW      = $clog2(MAX_OUTST + 1);
  localparam int unsigned ENTRY_W = XLEN + INST_W;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   drop_cnt;
  logic [XLEN-1:0] jump_tgt;
  logic            unused_jump_lsb;
  logic            credit_ok;
  logic            accept;
  logic            rsp_drop;
  logic            rsp_live;
  logic            bypass;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic            fifo_full;
  entry_t          rsp_entry;
  entry_t          fifo_head;
  entry_t          head;

  assign jump_tgt        = {jumpAddrIn[XLEN-1:2], 2'b00};
  assign unused_jump_lsb = ^jumpAddrIn[1:0];

  // In-flight responses still owed a slot are counted against the queue; stale ones are not.
  assign credit_ok = (32'(occupancyOut) + 32'(outstanding) - 32'(drop_cnt)) < 32'(DEPTH);
  assign imReqValidOut = credit_ok & (outstanding < OW'(MAX_OUTST)) & ~jumpEnIn & ~rst;
  assign imAddrOut     = fetch_pc;
  assign accept        = imReqValidOut & imReqReadyIn;

  assign rsp_drop  = imRspValidIn & (drop_cnt != '0);
  assign rsp_live  = imRspValidIn & (drop_cnt == '0) & ~jumpEnIn;
  assign rsp_entry = '{pc: rsp_pc, inst: imRspDataIn};

`ifdef RVX_FETCH_BYPASS_EN
  assign bypass = fifo_empty & rsp_live;
`else
  assign bypass = 1'b0;
`endif

  assign push = rsp_live & ~(bypass & idReadyIn);
  assign pop  = idReadyIn & ~fifo_empty;

  rvx_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (jumpEnIn),
    .push      (push),
    .push_data (rsp_entry),
    .pop       (pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (occupancyOut)
  );

  assign head        = bypass ? rsp_entry : fifo_head;
  assign ifValidOut  = ~fifo_empty | bypass;
  assign ifInstOut   = ifValidOut ? head.inst : NOP_INST;
  assign ifPcOut     = ifValidOut ? head.pc : '0;
  assign ifPcPlusOut = ifPcOut + XLEN'(PC_STEP);

  // A jump retargets both PCs and marks every response not arriving this cycle as stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + OW'(accept) - OW'(imRspValidIn);
      if (jumpEnIn) begin
        fetch_pc <= jump_tgt;
        rsp_pc   <= jump_tgt;
        drop_cnt <= outstanding - OW'(imRspValidIn);
      end else begin
        if (accept)   fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        if (rsp_live) rsp_pc   <= rsp_pc + XLEN'(PC_STEP);
        if (rsp_drop) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

  a_rsp_with_credit: assert property (@(posedge clk) disable iff (rst)
    !(imRspValidIn && (outstanding == '0)));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full && !pop && !jumpEnIn));

endmodule

// File: tb/tb_rvx_fetch_queue.sv
// Directed bench for rvx_fetch_queue with a latency-1 in-order IM model.
module tb_rvx_fetch_queue;
  import rvx_fetch_pkg::*;

`ifdef RVX_FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imReqValidOut;
  logic        imReqReadyIn;
  logic [31:0] imAddrOut;
  logic        imRspValidIn;
  logic [31:0] imRspDataIn;
  logic        jumpEnIn;
  logic [31:0] jumpAddrIn;
  logic        idReadyIn;
  logic        ifValidOut;
  logic [31:0] ifInstOut;
  logic [31:0] ifPcOut;
  logic [31:0] ifPcPlusOut;
  logic [2:0]  occupancyOut;

  int          n_vec = 0;
  int          n_err = 0;
  int          acc_cnt = 0;
  bit          rsp_en = 1'b0;
  logic [31:0] pend_q [$];
  logic [31:0] stream_pc [4];

  always #5 clk = ~clk;

  rvx_fetch_queue dut (
    .clk           (clk),
    .rst           (rst),
    .imReqValidOut (imReqValidOut),
    .imReqReadyIn  (imReqReadyIn),
    .imAddrOut     (imAddrOut),
    .imRspValidIn  (imRspValidIn),
    .imRspDataIn   (imRspDataIn),
    .jumpEnIn      (jumpEnIn),
    .jumpAddrIn    (jumpAddrIn),
    .idReadyIn     (idReadyIn),
    .ifValidOut    (ifValidOut),
    .ifInstOut     (ifInstOut),
    .ifPcOut       (ifPcOut),
    .ifPcPlusOut   (ifPcPlusOut),
    .occupancyOut  (occupancyOut)
  );

  function automatic logic [31:0] im_data(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample the request handshake, then the IM answers in order one cycle later.
  task automatic cyc();
    logic        acc;
    logic [31:0] acc_addr;
    logic        rsp_was;
    #1;
    acc      = imReqValidOut && imReqReadyIn;
    acc_addr = imAddrOut;
    rsp_was  = imRspValidIn;
    @(posedge clk);
    #1;
    if (rsp_was && pend_q.size() > 0) pend_q.delete(0);
    if (acc) begin
      pend_q.push_back(acc_addr);
      acc_cnt++;
    end
    imRspValidIn = rsp_en && (pend_q.size() > 0);
    imRspDataIn  = imRspValidIn ? im_data(pend_q[0]) : 32'h0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    imRspValidIn = 1'b0;
    imRspDataIn  = 32'h0;
    jumpEnIn     = 1'b0;
    idReadyIn    = 1'b0;
    pend_q.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_valid", 64'(imReqValidOut), 64'(0));
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!ifValidOut && n < 20) begin
      cyc();
      n++;
    end
    if (!ifValidOut) check_eq(tag, 64'(ifValidOut), 64'(1));
  endtask

  initial begin
    rst          = 1'b1;
    imReqReadyIn = 1'b0;
    imRspValidIn = 1'b0;
    imRspDataIn  = 32'h0;
    jumpEnIn     = 1'b0;
    jumpAddrIn   = 32'h0;
    idReadyIn    = 1'b0;
    if (BYP) stream_pc = '{32'h4, 32'h8, 32'hC, 32'h10};
    else     stream_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
    @(negedge clk);

    // Reset state
    do_reset();
    check_eq("rst_req_valid_rel", 64'(imReqValidOut), 64'(1));
    check_eq("rst_addr",          64'(imAddrOut),     64'(0));
    check_eq("rst_if_valid",      64'(ifValidOut),    64'(0));
    check_eq("rst_inst_nop",      64'(ifInstOut),     64'(32'h0000_0013));
    check_eq("rst_pc",            64'(ifPcOut),       64'(0));
    check_eq("rst_occ",           64'(occupancyOut),  64'(0));

    // Streaming at one instruction per cycle
    imReqReadyIn = 1'b1;
    idReadyIn    = 1'b1;
    rsp_en       = 1'b1;
    cyc();
    check_eq("stream_first_lat", 64'(ifValidOut), 64'(BYP));
    for (int k = 0; k < 4; k++) begin
      cyc();
      check_eq("stream_valid", 64'(ifValidOut),  64'(1));
      check_eq("stream_pc",    64'(ifPcOut),     64'(stream_pc[k]));
      check_eq("stream_pcp4",  64'(ifPcPlusOut), 64'(stream_pc[k] + 32'h4));
      check_eq("stream_inst",  64'(ifInstOut),   64'(im_data(stream_pc[k])));
    end

    // Jump coinciding with a response and a pop
    jumpEnIn   = 1'b1;
    jumpAddrIn = 32'h200;
    #1;
    check_eq("jmp_req_blocked", 64'(imReqValidOut), 64'(0));
    cyc();
    jumpEnIn  = 1'b0;
    idReadyIn = 1'b0;
    #1;
    check_eq("jmp_flush_valid", 64'(ifValidOut),   64'(0));
    check_eq("jmp_flush_occ",   64'(occupancyOut), 64'(0));
    check_eq("jmp_addr",        64'(imAddrOut),    64'(32'h200));
    wait_valid("jmp_wait_timeout");
    check_eq("jmp_head_pc",   64'(ifPcOut),   64'(32'h200));
    check_eq("jmp_head_inst", 64'(ifInstOut), 64'(32'hC0DE_0200));

    // Backpressure: credits stop requests once the queue is spoken for
    do_reset();
    imReqReadyIn = 1'b1;
    rsp_en       = 1'b1;
    acc_cnt      = 0;
    repeat (10) cyc();
    check_eq("bp_accepts",   64'(acc_cnt),       64'(4));
    check_eq("bp_occ_full",  64'(occupancyOut),  64'(4));
    check_eq("bp_req_drop",  64'(imReqValidOut), 64'(0));
    check_eq("bp_head_pc",   64'(ifPcOut),       64'(0));
    idReadyIn = 1'b1;
    cyc();
    idReadyIn = 1'b0;
    #1;
    check_eq("bp_pop_occ",   64'(occupancyOut),  64'(3));
    check_eq("bp_pop_pc",    64'(ifPcOut),       64'(32'h4));
    check_eq("bp_pop_req",   64'(imReqValidOut), 64'(1));
    acc_cnt = 0;
    repeat (6) cyc();
    check_eq("bp_one_more",  64'(acc_cnt),       64'(1));
    check_eq("bp_refill",    64'(occupancyOut),  64'(4));
    check_eq("bp_next_addr", 64'(imAddrOut),     64'(32'h14));

    // Jump with two requests in flight: both stale responses are discarded
    do_reset();
    imReqReadyIn = 1'b1;
    rsp_en       = 1'b0;
    jumpEnIn     = 1'b1;
    jumpAddrIn   = 32'h13;
    #1;
    check_eq("jc_req_blocked", 64'(imReqValidOut), 64'(0));
    cyc();
    jumpEnIn = 1'b0;
    #1;
    check_eq("jc_addr_lsb_clr", 64'(imAddrOut),     64'(32'h10));
    check_eq("jc_req_valid",    64'(imReqValidOut), 64'(1));
    acc_cnt = 0;
    repeat (3) cyc();
    check_eq("jc_outst_limit",  64'(acc_cnt),       64'(2));
    check_eq("jc_outst_block",  64'(imReqValidOut), 64'(0));
    check_eq("jc_outst_addr",   64'(imAddrOut),     64'(32'h18));
    jumpEnIn   = 1'b1;
    jumpAddrIn = 32'h100;
    cyc();
    jumpEnIn = 1'b0;
    rsp_en   = 1'b1;
    wait_valid("jc_wait_timeout");
    check_eq("jc_head_pc",   64'(ifPcOut),     64'(32'h100));
    check_eq("jc_head_inst", 64'(ifInstOut),   64'(32'hC0DE_0100));
    check_eq("jc_head_pcp4", 64'(ifPcPlusOut), 64'(32'h104));

    // Response-to-ID latency from an empty queue
    do_reset();
    imReqReadyIn = 1'b1;
    rsp_en       = 1'b1;
    cyc();
    check_eq("lat_arrive_valid", 64'(ifValidOut), 64'(BYP));
    cyc();
    check_eq("lat_next_valid",   64'(ifValidOut), 64'(1));
    check_eq("lat_next_pc",      64'(ifPcOut),    64'(0));
    check_eq("lat_next_inst",    64'(ifInstOut),  64'(32'hC0DE_0000));

    // PC wrap at the top of the address space
    do_reset();
    imReqReadyIn = 1'b1;
    rsp_en       = 1'b1;
    jumpEnIn     = 1'b1;
    jumpAddrIn   = 32'hFFFF_FFFF;
    cyc();
    jumpEnIn = 1'b0;
    wait_valid("wrap_wait_timeout");
    check_eq("wrap_pc",   64'(ifPcOut),     64'(32'hFFFF_FFFC));
    check_eq("wrap_pcp4", 64'(ifPcPlusOut), 64'(0));
    check_eq("wrap_inst", 64'(ifInstOut),   64'(32'h3F21_FFFC));
    idReadyIn = 1'b1;
    cyc();
    idReadyIn = 1'b0;
    #1;
    check_eq("wrap_next_pc",   64'(ifPcOut),   64'(0));
    check_eq("wrap_next_inst", 64'(ifInstOut), 64'(32'hC0DE_0000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rvx_fetch_queue.md
Name: rvx_fetch_queue

Overview:
Parametrised instruction-fetch front end for the RVX 5-stage core, replacing the fixed single-cycle IF path.
- Issues sequential fetch requests over a valid/ready IM interface with variable response latency.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them to ID through a valid/ready handshake.
- On a jump: redirects the PC, flushes the queue and discards stale in-flight responses.

Parameters:
XLEN, 32, PC/address width
DEPTH, 4, instruction queue entries (power of 2, >=2)
MAX_OUTST, 2, maximum IM requests in flight (>=1)
RESET_PC, 0, fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
imReqValidOut  out  1  fetch request valid
imReqReadyIn  in  1  IM accepts request this cycle
imAddrOut  out  XLEN  fetch address
imRspValidIn  in  1  instruction returned (in request order)
imRspDataIn  in  32  returned instruction
jumpEnIn  in  1  redirect/flush request
jumpAddrIn  in  XLEN  redirect target
idReadyIn  in  1  ID consumes head this cycle
ifValidOut  out  1  head entry valid
ifInstOut  out  32  head instruction
ifPcOut  out  XLEN  head PC
ifPcPlusOut  out  XLEN  head PC + 4
occupancyOut  out  $clog2(DEPTH)+1  current queue count

Behaviour:
- One clock. Reset is synchronous and active-high: rst sampled high on a clk edge resets all state.
- Reset values:
  - fetchPc = RESET_PC; rspPc = RESET_PC.
  - outstanding = 0; dropCnt = 0; queue empty.
  - ifValidOut = 0; ifInstOut = 32'h00000013 (NOP) while empty; ifPcOut = 0; occupancyOut = 0.
- rst mid-operation: all in-flight responses are lost; IM is reset together with the core.
- Request issue:
  - imReqValidOut = (occupancy + outstanding - dropCnt < DEPTH) & (outstanding < MAX_OUTST) & ~jumpEnIn & ~rst.
  - imAddrOut = fetchPc.
  - Accept = valid & ready; on accept, fetchPc += 4 and outstanding += 1.
  - No valid-stability rule: a request may be withdrawn, and IM samples only on the accept cycle.
- Response:
  - Each imRspValidIn decrements outstanding.
  - If dropCnt > 0: the response is discarded and dropCnt -= 1.
  - Otherwise it is pushed as {rspPc, data} and rspPc += 4.
  - The credit rule guarantees the push never overflows. An overflow attempt is an assertion failure.
  - imRspValidIn with outstanding == 0 is illegal (assertion).
- Dequeue: pop when ifValidOut & idReadyIn. ifPcPlusOut = ifPcOut + 4, mod 2^XLEN.
- Queue latency: a response is visible on ifValidOut the cycle after it arrives.
- Redirect (jumpEnIn = 1 at edge t):
  - Queue cleared; fetchPc = rspPc = jumpAddrIn.
  - dropCnt = outstanding - (imRspValidIn ? 1 : 0).
  - No request is issued in cycle t.
  - A response arriving in cycle t is dropped.
  - A pop in cycle t is permitted, but the flush wins.
- Jump has priority over push and pop. Push and pop in the same cycle leave occupancy unchanged.
- PC arithmetic wraps modulo 2^XLEN; jumpAddrIn[1:0] is ignored (forced to 0).
- Throughput: 1 instr/cycle sustained when the IM responds with fixed latency L and MAX_OUTST >= L+1.

Optional Feature:
RVX_FETCH_BYPASS_EN
- Defined: when the queue is empty, dropCnt == 0 and a response arrives, it drives ifValidOut/ifInstOut/ifPcOut combinationally in the same cycle. If idReadyIn is high it is consumed without entering the queue; otherwise it is pushed.
- Undefined: no bypass; minimum response-to-ID latency is 1 cycle.

Decomposition:
- Package rvx_fetch_pkg: NOP_INST = 32'h00000013, PC_STEP = 4, queue entry typedef {pc[XLEN-1:0], inst[31:0]}.
- Sub-module rvx_sync_fifo (parameters WIDTH, DEPTH; synchronous flush input, count output) holds the queue.
- Credit, drop and PC logic stay in rvx_fetch_queue.

Test Plan:
- Reset with rst=1 for 2 cycles, then release -> imAddrOut=0x0, imReqValidOut=1; ifValidOut=0; ifInstOut=0x00000013.
- IM fixed latency 1, ready=1, idReadyIn=1 -> ifPcOut runs 0x0, 0x4, 0x8… one per cycle after 2-cycle fill; ifPcPlusOut = ifPcOut + 4.
- idReadyIn=0, DEPTH=4, MAX_OUTST=2 -> exactly 4 requests are accepted, occupancyOut saturates at 4 and imReqValidOut drops; after one pop, exactly one new request is issued.
- With 2 requests outstanding (0x10, 0x14), assert jumpEnIn with jumpAddrIn=0x100 -> both stale responses are dropped, and the next ifPcOut is 0x100 with the data returned for address 0x100.
- Jump in the same cycle as a response and a pop -> the response is dropped, the queue is empty next cycle and dropCnt = outstanding-1.
- Bypass build, queue empty, latency-1 IM -> the response appears on ifValidOut in its arrival cycle. Non-bypass build -> the same response appears one cycle later.
